// File: rtl/memory_stage_pkg.sv
// Shared constants for the data-memory stage: opcodes, access sizes, fault codes and FSM states.
package memory_stage_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h00000013;

  localparam logic [6:0] LCC = 7'b0000011;
  localparam logic [6:0] SCC = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } fault_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Aligns a raw memory word to the addressed byte lane and sign/zero-extends it by load size.
module load_align
  import memory_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'h000000, shifted[7:0]};
      F3_LHU:  data = {16'h0000, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// X/M pipeline register, data-memory req/ack access FSM with timeout, and M/W register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_x,
  input  logic [31:0] inst_x,
  input  logic [31:0] alu_x,
  input  logic [31:0] rs2_x,
  input  logic        wm_bypass,
  input  logic [31:0] wb_w_bypass,
  output logic [31:0] PC_m,
  output logic [31:0] inst_m,
  output logic [31:0] alu_m,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] PC_w,
  output logic [31:0] inst_w,
  output logic [31:0] alu_w,
  output logic [31:0] load_w,
  output logic [1:0]  fault_w
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_WAIT - 1);

  logic [31:0]     rs2_m;
  mem_state_e      state;
  logic [CW-1:0]   wait_cnt;

  logic            is_load, is_store, mem_op, misaligned, timeout;
  logic [1:0]      size, off;
  logic [31:0]     sd, load_data;

  assign is_load    = inst_m[6:0] == LCC;
  assign is_store   = inst_m[6:0] == SCC;
  assign mem_op     = is_load | is_store;
  assign size       = inst_m[13:12];
  assign off        = alu_m[1:0];
  assign misaligned = mem_op & is_misaligned(size, off);
  assign sd         = wm_bypass ? wb_w_bypass : rs2_m;

  // inst_m is frozen while stalled, so the request stays stable across WAIT without extra state.
  assign dmem_req  = mem_op & ~misaligned;
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = {alu_m[31:2], 2'b00};
  // The cycle that reaches the wait limit is the last request cycle; the stall is released in it.
  assign timeout   = dmem_req & ~dmem_ack & (wait_cnt == LAST_CYCLE);
  assign stall_m   = dmem_req & ~dmem_ack & ~timeout;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = '0;
    if (is_store) begin
      case (size)
        SZ_B: begin
          dmem_wdata = {4{sd[7:0]}};
          dmem_be    = 4'b0001 << off;
        end
        SZ_H: begin
          dmem_wdata = {2{sd[15:0]}};
          dmem_be    = off[1] ? 4'b1100 : 4'b0011;
        end
        default: dmem_wdata = sd;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (off),
    .funct3 (inst_m[14:12]),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_m     <= '0;
      inst_m   <= NOP_INST;
      alu_m    <= '0;
      rs2_m    <= '0;
      state    <= ST_IDLE;
      wait_cnt <= '0;
      PC_w     <= '0;
      inst_w   <= NOP_INST;
      alu_w    <= '0;
      load_w   <= '0;
      fault_w  <= FAULT_NONE;
    end else begin
      if (!stall_m) begin
        PC_m   <= PC_x;
        inst_m <= inst_x;
        alu_m  <= alu_x;
        rs2_m  <= rs2_x;
      end

      case (state)
        ST_IDLE: begin
          if (stall_m) begin
            state    <= ST_WAIT;
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (stall_m) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase

      PC_w  <= PC_m;
      alu_w <= alu_m;
      if (stall_m || misaligned || timeout) begin
        inst_w  <= NOP_INST;
        load_w  <= '0;
        fault_w <= misaligned ? FAULT_MISALIGN : (timeout ? FAULT_TIMEOUT : FAULT_NONE);
      end else begin
        inst_w  <= inst_m;
        load_w  <= is_load ? load_data : '0;
        fault_w <= FAULT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, multi-cycle corner sequences, random model check.
module tb_memory_stage;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam int unsigned MAXW  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_x, inst_x, alu_x, rs2_x, wb_w_bypass, dmem_rdata;
  logic        wm_bypass, dmem_ack;
  logic [31:0] PC_m, inst_m, alu_m, dmem_addr, dmem_wdata;
  logic [31:0] PC_w, inst_w, alu_w, load_w;
  logic        stall_m, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [1:0]  fault_w;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  memory_stage #(.NOP_INST(32'h00000013), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .PC_x(PC_x), .inst_x(inst_x), .alu_x(alu_x), .rs2_x(rs2_x),
    .wm_bypass(wm_bypass), .wb_w_bypass(wb_w_bypass),
    .PC_m(PC_m), .inst_m(inst_m), .alu_m(alu_m), .stall_m(stall_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .PC_w(PC_w), .inst_w(inst_w), .alu_w(alu_w), .load_w(load_w), .fault_w(fault_w)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] load;
    logic [1:0]  fault;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        byp;
    logic [31:0] wbv;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] load, input logic [1:0] fault);
    exp_t e;
    e.req = req; e.we = we; e.addr = addr; e.wdata = wdata;
    e.be = be; e.load = load; e.fault = fault;
    return e;
  endfunction

  // Reference: derived from access size in bytes and byte offset with plain arithmetic.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] rs2,
                                 input logic byp, input logic [31:0] wbv, input logic [31:0] rdata);
    exp_t e;
    int unsigned size, off;
    logic [31:0] sd;
    longint v, lim;
    e = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd0);
    if (inst[6:0] != 7'h03 && inst[6:0] != 7'h23) return e;
    size = 32'd1 << inst[13:12];
    off  = alu % 4;
    if ((alu % size) != 0) begin
      e.fault = 2'd1;
      return e;
    end
    e.req  = 1'b1;
    e.addr = alu - off;
    if (inst[6:0] == 7'h23) begin
      e.we = 1'b1;
      sd   = byp ? wbv : rs2;
      e.be = 4'(((32'd1 << size) - 32'd1) << off);
      if (size == 1)      e.wdata = 32'h01010101 * {24'h0, sd[7:0]};
      else if (size == 2) e.wdata = 32'h00010001 * {16'h0, sd[15:0]};
      else                e.wdata = sd;
    end else begin
      lim = longint'(1) << (8 * size);
      v   = longint'(rdata >> (8 * off)) % lim;
      if (!inst[14] && v >= lim / 2) v = v - lim;
      e.load = v[31:0];
    end
    return e;
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic byp,
                         input logic [31:0] wbv, input logic [31:0] rdata,
                         input int unsigned delay, input exp_t e);
    int unsigned stalls;
    @(negedge clk);
    PC_x = pc; inst_x = inst; alu_x = alu; rs2_x = rs2;
    wm_bypass = byp; wb_w_bypass = wbv; dmem_rdata = rdata; dmem_ack = 1'b0;
    @(posedge clk); #1;
    PC_x = 32'h44; inst_x = ADD; alu_x = 32'h77; rs2_x = 32'h0;
    stalls = 0;
    if (!e.req) begin
      @(negedge clk); #1;
      chk({nm, ".req"}, {31'h0, dmem_req}, 32'h0);
      chk({nm, ".stall"}, {31'h0, stall_m}, 32'h0);
      @(posedge clk); #1;
    end else begin
      for (int unsigned c = 0; c <= delay && c < MAXW; c++) begin
        @(negedge clk);
        dmem_ack = (c == delay);
        #1;
        chk({nm, ".req"}, {31'h0, dmem_req}, 32'h1);
        chk({nm, ".we"}, {31'h0, dmem_we}, {31'h0, e.we});
        chk({nm, ".addr"}, dmem_addr, e.addr);
        chk({nm, ".be"}, {28'h0, dmem_be}, {28'h0, e.be});
        if (e.we) chk({nm, ".wdata"}, dmem_wdata, e.wdata);
        if (stall_m) stalls++;
        @(posedge clk); #1;
        if (c != delay) begin
          chk({nm, ".bubble"}, inst_w, NOP);
          chk({nm, ".hold"}, inst_m, inst);
        end
      end
      dmem_ack = 1'b0;
      chk({nm, ".stalls"}, stalls, delay);
    end
    chk({nm, ".inst_w"}, inst_w, (e.fault != 2'd0) ? NOP : inst);
    chk({nm, ".fault_w"}, {30'h0, fault_w}, {30'h0, e.fault});
    chk({nm, ".load_w"}, load_w, e.load);
    chk({nm, ".alu_w"}, alu_w, alu);
    chk({nm, ".PC_w"}, PC_w, pc);
    chk({nm, ".next_m"}, inst_m, ADD);
  endtask

  vec_t tbl[13];

  initial begin
    int unsigned reqs, stalls;
    logic done;
    logic [2:0] lf3[5];
    logic [31:0] inst, alu, rs2, wbv, rdata, pc;
    logic byp;

    reset = 1'b1;
    PC_x = '0; inst_x = NOP; alu_x = '0; rs2_x = '0;
    wm_bypass = 1'b0; wb_w_bypass = '0; dmem_ack = 1'b0; dmem_rdata = '0;

    tbl[0]  = '{32'h0000A283, 32'h100, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF,
                mk(1, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 2'd0)};
    tbl[1]  = '{32'h00008283, 32'h103, 32'h0, 1'b0, 32'h0, 32'h80FF0000,
                mk(1, 0, 32'h100, 32'h0, 4'hF, 32'hFFFFFF80, 2'd0)};
    tbl[2]  = '{32'h00208023, 32'h102, 32'h12345678, 1'b0, 32'h0, 32'h0,
                mk(1, 1, 32'h100, 32'h78787878, 4'b0100, 32'h0, 2'd0)};
    tbl[3]  = '{32'h00009283, 32'h101, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFF,
                mk(0, 0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd1)};
    tbl[4]  = '{32'h0000D283, 32'h102, 32'h0, 1'b0, 32'h0, 32'h80010000,
                mk(1, 0, 32'h100, 32'h0, 4'hF, 32'h00008001, 2'd0)};
    tbl[5]  = '{32'h00009283, 32'h102, 32'h0, 1'b0, 32'h0, 32'h80010000,
                mk(1, 0, 32'h100, 32'h0, 4'hF, 32'hFFFF8001, 2'd0)};
    tbl[6]  = '{32'h0000C283, 32'h101, 32'h0, 1'b0, 32'h0, 32'h00009A00,
                mk(1, 0, 32'h100, 32'h0, 4'hF, 32'h0000009A, 2'd0)};
    tbl[7]  = '{32'h00209023, 32'h102, 32'hAAAABEEF, 1'b1, 32'h1111CAFE, 32'h0,
                mk(1, 1, 32'h100, 32'hCAFECAFE, 4'b1100, 32'h0, 2'd0)};
    tbl[8]  = '{32'h0020A023, 32'h200, 32'h01020304, 1'b0, 32'h0, 32'h0,
                mk(1, 1, 32'h200, 32'h01020304, 4'hF, 32'h0, 2'd0)};
    tbl[9]  = '{32'h0020A023, 32'h202, 32'h01020304, 1'b0, 32'h0, 32'h0,
                mk(0, 0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd1)};
    tbl[10] = '{ADD, 32'h55, 32'h0, 1'b0, 32'h0, 32'h0,
                mk(0, 0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd0)};
    tbl[11] = '{NOP, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                mk(0, 0, 32'h0, 32'h0, 4'hF, 32'h0, 2'd0)};
    tbl[12] = '{32'h00008283, 32'h100, 32'h0, 1'b0, 32'h0, 32'h1234567F,
                mk(1, 0, 32'h100, 32'h0, 4'hF, 32'h0000007F, 2'd0)};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.inst_m", inst_m, NOP);
    chk("rst.inst_w", inst_w, NOP);
    chk("rst.PC_m", PC_m, 32'h0);
    chk("rst.alu_m", alu_m, 32'h0);
    chk("rst.PC_w", PC_w, 32'h0);
    chk("rst.alu_w", alu_w, 32'h0);
    chk("rst.load_w", load_w, 32'h0);
    chk("rst.fault_w", {30'h0, fault_w}, 32'h0);
    chk("rst.stall", {31'h0, stall_m}, 32'h0);
    chk("rst.req", {31'h0, dmem_req}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), 32'h1000 + 32'(i * 4), tbl[i].inst, tbl[i].alu, tbl[i].rs2,
              tbl[i].byp, tbl[i].wbv, tbl[i].rdata, 0, tbl[i].e);

    // LB with ack in the fourth request cycle: three stall cycles.
    run_txn("lb_wait3", 32'h2000, tbl[1].inst, tbl[1].alu, 32'h0, 1'b0, 32'h0, tbl[1].rdata, 3, tbl[1].e);

    // Timeout: request held for MAXW cycles, then fault 2.
    @(negedge clk);
    PC_x = 32'h3000; inst_x = 32'h0000A283; alu_x = 32'h300; dmem_ack = 1'b0;
    @(posedge clk); #1;
    inst_x = NOP; alu_x = 32'h0;
    reqs = 0; stalls = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (dmem_req) reqs++;
      if (stall_m) stalls++;
      if (dmem_req && !stall_m) begin
        done = 1'b1;
        break;
      end
    end
    chk("to.done", {31'h0, done}, 32'h1);
    chk("to.reqs", reqs, MAXW);
    chk("to.stalls", stalls, MAXW - 1);
    @(posedge clk); #1;
    chk("to.inst_w", inst_w, NOP);
    chk("to.fault_w", {30'h0, fault_w}, 32'h2);
    chk("to.load_w", load_w, 32'h0);
    @(negedge clk); #1;
    chk("to.req_drop", {31'h0, dmem_req}, 32'h0);
    chk("to.stall_rel", {31'h0, stall_m}, 32'h0);

    // Asynchronous reset in the middle of a wait; a late ack must be ignored.
    @(negedge clk);
    PC_x = 32'h4000; inst_x = 32'h0000A283; alu_x = 32'h400;
    @(posedge clk); #1;
    inst_x = NOP; alu_x = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rw.req_before", {31'h0, dmem_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw.req", {31'h0, dmem_req}, 32'h0);
    chk("rw.inst_m", inst_m, NOP);
    chk("rw.inst_w", inst_w, NOP);
    chk("rw.stall", {31'h0, stall_m}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1;
    #1;
    chk("rw.late_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("rw.late_inst_w", inst_w, NOP);
    chk("rw.late_fault", {30'h0, fault_w}, 32'h0);

    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;
    for (int n = 0; n < 60; n++) begin
      inst = $urandom;
      case ($urandom_range(0, 3))
        0: begin inst[6:0] = 7'h03; inst[14:12] = lf3[$urandom_range(0, 4)]; end
        1: begin inst[6:0] = 7'h23; inst[14:12] = 3'($urandom_range(0, 2)); end
        2: begin inst[6:0] = 7'h33; if (inst[11:7] == 5'd0) inst[11:7] = 5'd1; end
        default: inst = NOP;
      endcase
      alu = $urandom; rs2 = $urandom; wbv = $urandom; rdata = $urandom; pc = $urandom;
      byp = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", n), pc, inst, alu, rs2, byp, wbv, rdata,
              $urandom_range(0, 5), model(inst, alu, rs2, byp, wbv, rdata));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
